// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle MULT/DIV unit: op encoding, FSM states, iteration count.
package mult_div_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER_N = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div_unit_divider_step.sv
// One restoring-division step on unsigned magnitudes; purely combinational.
module signed_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  assign w_shift = {i_rem, i_bit};
  assign w_trial = w_shift - {1'b0, i_dvsr};

  // Partial remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow flag.
  assign o_qbit = ~w_trial[WIDTH];
  assign o_rem  = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Signed multicycle MULT (radix-2 Booth) / DIV (restoring) unit producing HI/LO.
// Accepted start at edge k gives a one-cycle done after edge k+33; starts outside IDLE are ignored.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = ITER_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             start,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_p_hi;
  logic [WIDTH-1:0]   r_p_lo;
  logic               r_q;
  logic               r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_div_zero;

  logic               w_req;
  logic               w_zero_div;
  logic               w_accept;
  logic               w_busy;
  logic               w_done;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_booth_sum;
  logic [WIDTH-1:0]   w_rem;
  logic               w_qbit;

  assign w_req      = (r_state == IDLE) && start;
  assign w_zero_div = w_req && (op == OP_DIV) && (SrcB == '0);
  assign w_accept   = w_req && !w_zero_div;

  assign w_abs_a = SrcA[WIDTH-1] ? -SrcA : SrcA;
  assign w_abs_b = SrcB[WIDTH-1] ? -SrcB : SrcB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_accept) w_next = RUN;
      end
      RUN:  if (r_cnt == CNT_W'(ITER - 1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Booth sum is one bit wider than P_hi so that subtracting the most negative
  // multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    w_booth_sum = {r_p_hi[WIDTH-1], r_p_hi};
    case ({r_p_lo[0], r_q})
      2'b01:   w_booth_sum = {r_p_hi[WIDTH-1], r_p_hi} + {r_a[WIDTH-1], r_a};
      2'b10:   w_booth_sum = {r_p_hi[WIDTH-1], r_p_hi} - {r_a[WIDTH-1], r_a};
      default: w_booth_sum = {r_p_hi[WIDTH-1], r_p_hi};
    endcase
  end

  signed_divider_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem  (r_p_hi),
    .i_bit  (r_p_lo[WIDTH-1]),
    .i_dvsr (r_a),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  // For DIV, P_hi holds the partial remainder and P_lo shifts dividend bits out / quotient bits in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_p_hi     <= '0;
      r_p_lo     <= '0;
      r_q        <= 1'b0;
      r_op       <= OP_MULT;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_div_zero <= w_zero_div;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= op;
            r_p_hi  <= '0;
            r_q     <= 1'b0;
            r_neg_q <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
            r_neg_r <= SrcA[WIDTH-1];
            if (op == OP_DIV) begin
              r_a    <= w_abs_b;
              r_p_lo <= w_abs_a;
            end else begin
              r_a    <= SrcA;
              r_p_lo <= SrcB;
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op == OP_MULT) begin
            r_p_hi <= w_booth_sum[WIDTH:1];
            r_p_lo <= {w_booth_sum[0], r_p_lo[WIDTH-1:1]};
            r_q    <= r_p_lo[0];
          end else begin
            r_p_hi <= w_rem;
            r_p_lo <= {r_p_lo[WIDTH-2:0], w_qbit};
          end
        end
        FIX: begin
          if (r_op == OP_DIV) begin
            r_lo <= r_neg_q ? -r_p_lo : r_p_lo;
            r_hi <= r_neg_r ? -r_p_hi : r_p_hi;
          end else begin
            r_lo <= r_p_lo;
            r_hi <= r_p_hi;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign div_zero = r_div_zero;
  assign HI       = r_hi;
  assign LO       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed MULT/DIV corner cases, random ops, div-by-zero and mid-op reset.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        start;
  logic        op;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .start    (start),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic o);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) return sa * sb;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge with the DUT in IDLE; returns 1ns after the acceptance edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [63:0] exp, input bit push);
    SrcA  = a;
    SrcB  = b;
    op    = o;
    start = 1'b1;
    if (push) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    SrcA  = $urandom;
    SrcB  = $urandom;
    op    = ~o;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [63:0] exp, input int mid, input bit at_done);
    int n;
    int bcnt;
    bit got;
    logic [63:0] e;
    launch(a, b, o, exp, 1'b1);
    n = 0;
    bcnt = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (busy) bcnt++;
      if (done) got = 1'b1;
      start = (n == mid);
      if (n == mid) begin
        SrcA = 32'h1234_5678;
        SrcB = 32'h0000_0003;
        op   = 1'b0;
      end
    end
    chk("latency", 64'(n), 64'd34);
    chk("busy_cycles", 64'(bcnt), 64'd34);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk("HI", {32'h0, HI}, {32'h0, e[63:32]});
    chk("LO", {32'h0, LO}, {32'h0, e[31:0]});
    if (at_done) begin
      start = 1'b1;
      SrcA  = 32'd9;
      SrcB  = 32'd9;
      op    = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", {63'h0, busy}, 64'd0);
    chk("idle_done", {63'h0, done}, 64'd0);
  endtask

  initial begin
    int extra;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ro;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    SrcA  = '0;
    SrcB  = '0;
    @(negedge clk);
    chk("rst_HI", {32'h0, HI}, 64'd0);
    chk("rst_LO", {32'h0, LO}, 64'd0);
    chk("rst_busy", {63'h0, busy}, 64'd0);
    chk("rst_done", {63'h0, done}, 64'd0);
    chk("rst_dz", {63'h0, div_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'd7,         32'hFFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 64'h3FFF_FFFF_0000_0001, 0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2,         1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0);
    run_op(32'd7,         32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD, 0, 1'b0);
    run_op(32'h451,       32'h20,        1'b1, 64'h0000_0011_0000_0022, 0, 1'b0);

    // Divide by zero: flag only, no state change.
    SrcA  = 32'd5;
    SrcB  = 32'd0;
    op    = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("dz_pulse", {63'h0, div_zero}, 64'd1);
    chk("dz_busy", {63'h0, busy}, 64'd0);
    @(negedge clk);
    chk("dz_clear", {63'h0, div_zero}, 64'd0);
    chk("dz_nodone", {63'h0, done}, 64'd0);
    chk("dz_HI", {32'h0, HI}, 64'h11);
    chk("dz_LO", {32'h0, LO}, 64'h22);

    // Overflow divide with a stray start mid-RUN and another on the DONE edge.
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 5, 1'b1);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("extra_done", 64'(extra), 64'd0);
    chk("ovf_HI_hold", {32'h0, HI}, 64'd0);
    chk("ovf_LO_hold", {32'h0, LO}, 64'h8000_0000);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = i[0];
      if (i == 4) rb = 32'hFFFF_FFFF;
      if (ro && rb == 32'd0) rb = 32'd1;
      run_op(ra, rb, ro, model(ra, rb, ro), 0, 1'b0);
    end

    // Reset in the middle of a MULT; make sure HI/LO are non-zero beforehand.
    run_op(32'h0001_0003, 32'h0002_0005, 1'b0, 64'h0000_0002_000B_000F, 0, 1'b0);
    launch(32'h0000_1234, 32'h0000_5678, 1'b0, 64'd0, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_HI", {32'h0, HI}, 64'd0);
    chk("mid_rst_LO", {32'h0, LO}, 64'd0);
    chk("mid_rst_busy", {63'h0, busy}, 64'd0);
    chk("mid_rst_done", {63'h0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(32'd3, 32'd4, 1'b0, 64'd12, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
